// File: rtl/bounce_gen_pkg.sv
// bounce_gen_pkg: shared state encoding, LFSR constants and step function for bounce_gen
package bounce_gen_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BOUNCE = 2'd1, SETTLE = 2'd2} state_t;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    // Galois form of x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction
endpackage

// File: rtl/bounce_gen_lfsr16.sv
// lfsr16: 16-bit Galois LFSR, reseeded on reset, steps once per enabled cycle
module lfsr16 import bounce_gen_pkg::*; #(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);
    always_ff @(posedge clk or posedge rst)
        if (rst)     state <= SEED;
        else if (en) state <= lfsr_step(state);
endmodule

// File: rtl/bounce_gen.sv
// bounce_gen: turns a level request into a pseudo-random contact-bounce burst, then settles at the target level
module bounce_gen import bounce_gen_pkg::*; #(
    parameter int          BOUNCE_CYCLES = 64,
    parameter int          SETTLE_CYCLES = 8,
    parameter int          GAP_W         = 3,
    parameter logic [15:0] LFSR_SEED     = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       target,
    output logic       bouncy_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] toggle_cnt
);
    localparam int WW = $clog2(BOUNCE_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    state_t            state_q;
    logic              bouncy_q, busy_q, done_q, target_q;
    logic [7:0]        cnt_q;
    logic [WW-1:0]     win_q;
    logic [SW-1:0]     set_q;
    logic [GAP_W-1:0]  gap_q;
    logic [15:0]       lfsr;
    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == BOUNCE),
        .state(lfsr)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bouncy_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            target_q <= 1'b0;
            cnt_q    <= 8'd0;
            win_q    <= '0;
            set_q    <= '0;
            gap_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    cnt_q <= 8'd0;
                    if (target != bouncy_q) begin
                        target_q <= target;
                        win_q    <= WW'(BOUNCE_CYCLES);
                        gap_q    <= GAP_W'(lfsr);
                        busy_q   <= 1'b1;
                        state_q  <= BOUNCE;
                    end else done_q <= 1'b1;
                end
                BOUNCE: begin
                    win_q <= win_q - WW'(1);
                    if (gap_q == '0) begin
                        bouncy_q <= ~bouncy_q;
                        cnt_q    <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                        gap_q    <= GAP_W'(lfsr_step(lfsr));
                    end else gap_q <= gap_q - GAP_W'(1);
                    // last window cycle: force the requested level whatever the toggle parity
                    if (win_q == WW'(1)) begin
                        bouncy_q <= target_q;
                        set_q    <= SW'(SETTLE_CYCLES);
                        state_q  <= SETTLE;
                    end
                end
                SETTLE: begin
                    set_q <= set_q - SW'(1);
                    if (set_q == SW'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bouncy_out = bouncy_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign toggle_cnt = cnt_q;
endmodule

// File: tb/tb_bounce_gen.sv
// tb_bounce_gen: directed and randomized checks of bounce_gen against a burst-level reference model
module tb_bounce_gen;
    localparam int          B    = 16;
    localparam int          S    = 4;
    localparam int          G    = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 0, rst = 1, start = 0, target = 0;
    logic       bouncy_out, busy, done;
    logic [7:0] toggle_cnt;

    always #5 clk = ~clk;

    bounce_gen #(.BOUNCE_CYCLES(B), .SETTLE_CYCLES(S), .GAP_W(G), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .target(target),
        .bouncy_out(bouncy_out), .busy(busy), .done(done), .toggle_cnt(toggle_cnt)
    );

    typedef struct {logic b; logic bz; logic d; logic [7:0] c;} exp_t;
    exp_t       q[$];
    exp_t       ce;
    logic       m_level = 0;
    logic [7:0] m_cnt   = 0;
    logic [15:0] m_lfsr = SEED;
    int         chk = 0, err = 0;

    // simple counter debouncer fed by the emulated button
    logic db_cand = 0, db_out = 0;
    int   db_n = 0;
    always @(posedge clk)
        if (bouncy_out !== db_cand) begin
            db_cand <= bouncy_out;
            db_n    <= 0;
        end else if (db_n < 3) db_n <= db_n + 1;
        else db_out <= db_cand;

    function automatic logic [15:0] gstep(logic [15:0] s);
        logic lsb = s[0];
        s = s >> 1;
        if (lsb) s = s ^ 16'hB400;
        return s;
    endfunction

    function automatic logic [7:0] sat(int n);
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    task automatic check(string name, int got, int exp);
        chk++;
        if (got != exp) begin
            err++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Plan a whole burst: toggle instants come from successive LFSR gaps, outputs follow from them.
    task automatic model_start(logic t);
        bit         tog [B+1];
        logic [15:0] lf = m_lfsr;
        int         steps = 0, pos, n = 0;
        if (q.size() != 0) return;
        if (t == m_level) begin
            m_cnt = 0;
            q.push_back('{m_level, 1'b0, 1'b1, 8'd0});
            return;
        end
        foreach (tog[i]) tog[i] = 0;
        pos = int'(lf[G-1:0]) + 1;
        while (pos <= B) begin
            while (steps < pos) begin lf = gstep(lf); steps++; end
            tog[pos] = 1;
            pos += int'(lf[G-1:0]) + 1;
        end
        while (steps < B) begin lf = gstep(lf); steps++; end
        m_lfsr = lf;
        for (int k = 0; k < B; k++) begin
            if (k >= 1 && tog[k]) n++;
            q.push_back('{m_level ^ n[0], 1'b1, 1'b0, sat(n)});
        end
        if (tog[B]) n++;
        for (int s = 0; s < S; s++) q.push_back('{t, 1'b1, 1'b0, sat(n)});
        q.push_back('{t, 1'b0, 1'b1, sat(n)});
        m_level = t;
        m_cnt   = sat(n);
    endtask

    initial forever begin
        @(posedge clk); #1;
        if (!rst) begin
            if (q.size() > 0) ce = q.pop_front();
            else ce = '{m_level, 1'b0, 1'b0, m_cnt};
            chk++;
            if ({bouncy_out, busy, done, toggle_cnt} !== {ce.b, ce.bz, ce.d, ce.c}) begin
                err++;
                $display("FAIL cycle_cmp t=%0t got b=%b busy=%b done=%b cnt=%0d expected b=%b busy=%b done=%b cnt=%0d",
                         $time, bouncy_out, busy, done, toggle_cnt, ce.b, ce.bz, ce.d, ce.c);
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(logic s, logic t);
        start  = s;
        target = t;
        if (s) model_start(t);
    endtask

    task automatic req(logic t);
        @(negedge clk); drive(1, t);
        @(negedge clk); drive(0, t);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1;
        #1;
        check("rst_bouncy", bouncy_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", toggle_cnt, 0);
        q.delete();
        m_level = 0;
        m_cnt   = 0;
        m_lfsr  = SEED;
        @(negedge clk);
        start = 0;
        rst   = 0;
    endtask

    // hand-derived edges of the first rising burst after reset: toggles at window cycles 2,3,4,7,9,12,13,16
    task automatic golden();
        check("g_busy_t1", busy, 1);
        check("g_b_t1", bouncy_out, 0);
        cyc(1); check("g_b_t2", bouncy_out, 0);
        cyc(1); check("g_b_t3", bouncy_out, 1);
        cyc(1); check("g_b_t4", bouncy_out, 0);
        cyc(1); check("g_b_t5", bouncy_out, 1);
        cyc(12);
        check("g_b_t17", bouncy_out, 1);
        check("g_cnt_t17", toggle_cnt, 8);
        check("g_busy_t17", busy, 1);
        cyc(3); check("g_done_t20", done, 0);
        cyc(1);
        check("g_done_t21", done, 1);
        check("g_busy_t21", busy, 0);
        check("g_cnt_t21", toggle_cnt, 8);
        check("g_b_t21", bouncy_out, 1);
    endtask

    initial begin
        int dn, at, glitch, r;
        do_reset();
        cyc(2);
        req(1);
        golden();
        cyc(3);
        req(1);
        check("noop_done", done, 1);
        check("noop_busy", busy, 0);
        check("noop_cnt", toggle_cnt, 0);
        check("noop_b", bouncy_out, 1);
        cyc(4);
        req(0);
        cyc(16); check("fall_b_t17", bouncy_out, 0);
        cyc(4);  check("fall_done_t21", done, 1);
        cyc(2);
        glitch = 0;
        for (int i = 0; i < 8; i++) begin
            if (db_out !== 1'b0) glitch++;
            cyc(1);
        end
        check("fall_db_glitches", glitch, 0);
        req(1);
        cyc(4); drive(1, 0);
        cyc(1); drive(0, 0);
        dn = 0; at = 0;
        for (int i = 7; i <= 25; i++) begin
            cyc(1);
            if (done) begin dn++; at = i; end
        end
        check("rej_done_count", dn, 1);
        check("rej_done_time", at, 21);
        check("rej_b_final", bouncy_out, 1);
        do_reset();
        req(1);
        cyc(6);
        do_reset();
        req(1);
        golden();
        repeat (400) begin
            @(negedge clk);
            r = $urandom_range(0, 199);
            if (r == 0) do_reset();
            else drive(r < 50, 1'($urandom_range(0, 1)));
        end
        @(negedge clk); drive(0, 0);
        cyc(30);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
